// File: rtl/mem_write_scheduler.sv
// Issue stage for a dual-write / single-read register memory: buffers single writes,
// drains up to two per cycle (older on port 1), and holds reads off addresses still pending.
module mem_write_scheduler #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [AW-1:0]            rd_addr,
  input  logic                     stall,
  output logic                     we1,
  output logic [AW-1:0]            wa1,
  output logic [DW-1:0]            wd1,
  output logic                     we2,
  output logic [AW-1:0]            wa2,
  output logic [DW-1:0]            wd2,
  output logic                     re,
  output logic [AW-1:0]            ra,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_TWO  = (PW+1)'(2);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [AW-1:0]    addr_reg [DEPTH];
  logic [DW-1:0]    data_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]      count_reg;

  logic [PW-1:0]    rd_ptr_next, wr_ptr_next, second_ptr;
  logic [PW:0]      count_next, pop_cnt;
  logic             push, issue_one, issue_two;
  logic [DEPTH-1:0] hit;

  assign count    = count_reg;
  assign wr_ready = (count_reg < CNT_FULL);
  assign push     = wr_valid && wr_ready;

  assign issue_one  = !stall && (count_reg != '0);
  assign issue_two  = !stall && (count_reg >= CNT_TWO);
  assign second_ptr = rd_ptr_reg + PTR_ONE;

  always_comb begin
    pop_cnt = '0;
    if (issue_two)      pop_cnt = CNT_TWO;
    else if (issue_one) pop_cnt = CNT_ONE;
  end

  assign we1 = issue_one;
  assign wa1 = issue_one ? addr_reg[rd_ptr_reg] : '0;
  assign wd1 = issue_one ? data_reg[rd_ptr_reg] : '0;
  assign we2 = issue_two;
  assign wa2 = issue_two ? addr_reg[second_ptr] : '0;
  assign wd2 = issue_two ? data_reg[second_ptr] : '0;

  // An entry is live when its distance from the head is below count; live entries
  // (including the pair leaving this cycle) block reads to the same address.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [PW-1:0] slot_off;
      assign slot_off = PW'(gi) - rd_ptr_reg;
      assign hit[gi]  = ({1'b0, slot_off} < count_reg) && (addr_reg[gi] == rd_addr);
    end
  endgenerate

  assign rd_ready = !stall && (hit == '0);
  assign re       = rd_valid && rd_ready;
  assign ra       = re ? rd_addr : '0;

  assign count_next  = count_reg + {{PW{1'b0}}, push} - pop_cnt;
  assign rd_ptr_next = rd_ptr_reg + pop_cnt[PW-1:0];
  assign wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      // At full a push is never accepted, so the tail slot is always free here.
      if (push) begin
        addr_reg[wr_ptr_reg] <= wr_addr;
        data_reg[wr_ptr_reg] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_scheduler.sv
// Directed bench for mem_write_scheduler: one task per scenario with hand-computed
// expected values; inputs change 1 time unit after the rising edge, checks follow shortly after.
module tb_mem_write_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_addr, wr_data;
  logic       rd_valid, rd_ready;
  logic [3:0] rd_addr;
  logic       stall;
  logic       we1, we2, re;
  logic [3:0] wa1, wd1, wa2, wd2, ra;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  mem_write_scheduler #(.AW(4), .DW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .stall(stall),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .re(re), .ra(ra), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stalled(input logic [3:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    $display("push addr=%0h data=%0h count=%0d", a, d, count);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({we1, we2, re} !== 3'b000) begin errors++; $display("FAIL reset_en got=%b exp=000", {we1, we2, re}); end
    checks++; if ({wa1, wd1, wa2, wd2, ra} !== 20'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {wa1, wd1, wa2, wd2, ra}); end
    checks++; if ({wr_ready, rd_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", {wr_ready, rd_ready}); end
    $display("reset done count=%0d", count);
  endtask

  task automatic test_single_writes();
    wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 4'h5;
    step();
    wr_addr = 4'h7; wr_data = 4'h9;
    #1;
    checks++; if ({we1, wa1, wd1} !== {1'b1, 4'h3, 4'h5}) begin errors++; $display("FAIL single1_p1 got=%b/%h/%h exp=1/3/5", we1, wa1, wd1); end
    checks++; if ({we2, wa2, wd2} !== 9'h0) begin errors++; $display("FAIL single1_p2 got=%b/%h/%h exp=0/0/0", we2, wa2, wd2); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if ({we1, wa1, wd1} !== {1'b1, 4'h7, 4'h9}) begin errors++; $display("FAIL single2_p1 got=%b/%h/%h exp=1/7/9", we1, wa1, wd1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL single2_p2 got=%b exp=0", we2); end
    step();
    checks++; if ({count, we1} !== {3'd0, 1'b0}) begin errors++; $display("FAIL single_drain got=%0d/%b exp=0/0", count, we1); end
    $display("single writes issued count=%0d", count);
  endtask

  task automatic test_pair_drain();
    stall = 1'b1;
    push_stalled(4'h2, 4'h1);
    push_stalled(4'h2, 4'h4);
    push_stalled(4'h6, 4'h8);
    push_stalled(4'h1, 4'h1);
    wr_valid = 1'b0;
    #1;
    checks++; if ({count, wr_ready, we1, we2} !== {3'd4, 3'b000}) begin errors++; $display("FAIL full_stalled got=%0d/%b/%b/%b exp=4/0/0/0", count, wr_ready, we1, we2); end
    stall = 1'b0;
    #1;
    checks++; if ({we1, wa1, wd1, we2, wa2, wd2} !== {1'b1, 4'h2, 4'h1, 1'b1, 4'h2, 4'h4}) begin errors++; $display("FAIL pair1 got=%b%h%h %b%h%h exp=121 124", we1, wa1, wd1, we2, wa2, wd2); end
    step();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL pair_count1 got=%0d exp=2", count); end
    checks++; if ({we1, wa1, wd1, we2, wa2, wd2} !== {1'b1, 4'h6, 4'h8, 1'b1, 4'h1, 4'h1}) begin errors++; $display("FAIL pair2 got=%b%h%h %b%h%h exp=168 111", we1, wa1, wd1, we2, wa2, wd2); end
    step();
    checks++; if ({count, we1, we2} !== {3'd0, 2'b00}) begin errors++; $display("FAIL pair_drain got=%0d/%b/%b exp=0/0/0", count, we1, we2); end
    $display("pair drain done count=%0d", count);
  endtask

  task automatic test_read_gating();
    stall = 1'b1;
    push_stalled(4'h5, 4'hA);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'h5;
    #1;
    checks++; if ({rd_ready, re} !== 2'b00) begin errors++; $display("FAIL rd_block_hit got=%b/%b exp=0/0", rd_ready, re); end
    rd_addr = 4'h4;
    #1;
    checks++; if ({rd_ready, re} !== 2'b00) begin errors++; $display("FAIL rd_block_stall got=%b/%b exp=0/0", rd_ready, re); end
    rd_addr = 4'h5; stall = 1'b0;
    #1;
    checks++; if ({we1, wa1, wd1, rd_ready, re, ra} !== {1'b1, 4'h5, 4'hA, 2'b00, 4'h0}) begin errors++; $display("FAIL rd_during_issue got=%b%h%h rdy=%b re=%b ra=%h exp=15A 0 0 0", we1, wa1, wd1, rd_ready, re, ra); end
    step();
    checks++; if ({rd_ready, re, ra, we1} !== {2'b11, 4'h5, 1'b0}) begin errors++; $display("FAIL rd_after_drain got=rdy%b re%b ra%h we1%b exp=1 1 5 0", rd_ready, re, ra, we1); end
    $display("read addr=5 issued after drain");
    // Push and read of the same address in one cycle: the read goes first.
    wr_valid = 1'b1; wr_addr = 4'h8; wr_data = 4'h3; rd_addr = 4'h8;
    #1;
    checks++; if ({re, ra} !== {1'b1, 4'h8}) begin errors++; $display("FAIL rd_same_push got=%b/%h exp=1/8", re, ra); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if ({rd_ready, re, we1, wa1} !== {3'b001, 4'h8}) begin errors++; $display("FAIL rd_after_push got=%b%b%b/%h exp=001/8", rd_ready, re, we1, wa1); end
    step();
    rd_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rd_final_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1;
    push_stalled(4'h1, 4'h2);
    push_stalled(4'h3, 4'h4);
    push_stalled(4'h5, 4'h6);
    push_stalled(4'h7, 4'h8);
    wr_addr = 4'h9; wr_data = 4'hC; stall = 1'b0;
    #1;
    checks++; if ({wr_ready, we1, wa1, wd1, we2, wa2, wd2} !== {2'b01, 4'h1, 4'h2, 1'b1, 4'h3, 4'h4}) begin errors++; $display("FAIL b2b_full got=rdy%b %b%h%h %b%h%h exp=0 112 134", wr_ready, we1, wa1, wd1, we2, wa2, wd2); end
    step();
    checks++; if ({count, wr_ready} !== {3'd2, 1'b1}) begin errors++; $display("FAIL b2b_count2 got=%0d/%b exp=2/1", count, wr_ready); end
    checks++; if ({we1, wa1, wd1, we2, wa2, wd2} !== {1'b1, 4'h5, 4'h6, 1'b1, 4'h7, 4'h8}) begin errors++; $display("FAIL b2b_pair2 got=%b%h%h %b%h%h exp=156 178", we1, wa1, wd1, we2, wa2, wd2); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count1 got=%0d exp=1", count); end
    checks++; if ({we1, wa1, wd1, we2} !== {1'b1, 4'h9, 4'hC, 1'b0}) begin errors++; $display("FAIL b2b_wrapped got=%b%h%h we2=%b exp=19C 0", we1, wa1, wd1, we2); end
    step();
    checks++; if ({count, we1} !== {3'd0, 1'b0}) begin errors++; $display("FAIL b2b_drain got=%0d/%b exp=0/0", count, we1); end
    $display("back-to-back wrapped entry drained count=%0d", count);
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    push_stalled(4'hA, 4'h1);
    push_stalled(4'hB, 4'h2);
    push_stalled(4'hC, 4'h3);
    wr_valid = 1'b0; stall = 1'b0; rd_valid = 1'b1; rd_addr = 4'h0;
    #1;
    checks++; if ({count, we1, we2, re} !== {3'd3, 3'b111}) begin errors++; $display("FAIL pre_reset got=%0d/%b%b%b exp=3/111", count, we1, we2, re); end
    rst_n = 1'b0;
    #1;
    checks++; if ({we1, we2, count} !== {2'b00, 3'd0}) begin errors++; $display("FAIL async_drop got=%b%b/%0d exp=00/0", we1, we2, count); end
    rd_valid = 1'b0;
    #1;
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL async_re got=%b exp=0", re); end
    rst_n = 1'b1;
    step();
    checks++; if ({count, we1, we2, wa1} !== {3'd0, 2'b00, 4'h0}) begin errors++; $display("FAIL post_reset got=%0d/%b%b/%h exp=0/00/0", count, we1, we2, wa1); end
    step();
    checks++; if ({we1, we2, wr_ready} !== 3'b001) begin errors++; $display("FAIL post_reset_idle got=%b exp=001", {we1, we2, wr_ready}); end
    $display("async reset cleared pending writes count=%0d", count);
  endtask

  initial begin
    test_reset();
    test_single_writes();
    test_pair_drain();
    test_read_gating();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
